// File: rtl/sha3_pkg.sv
// Shared SHA3 state types, lane counts and the lane byte-reversal helper.
package sha3_pkg;

   localparam int SHA3_LANES            = 25;
   localparam int SHA3_256_DIGEST_LANES = 4;

   typedef logic [63:0]  lane_t;
   typedef lane_t [0:4]  plane_t;
   typedef plane_t [0:4] state_t;

   function automatic lane_t lane_byteswap(input lane_t l);
      return {<<8{l}};
   endfunction

endpackage

// File: rtl/sha3_state_buffer.sv
// Registered store for the first N_LANES lanes of one SHA3 state.
// load_i captures d_i and sets valid; clear_i drops validity; rst zeroes everything.
module sha3_state_buffer
   import sha3_pkg::*;
#(
   parameter int N_LANES = SHA3_256_DIGEST_LANES
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  load_i,
   input  logic  clear_i,
   input  lane_t d_i [N_LANES],
   output lane_t q_o [N_LANES],
   output logic  valid_o
);

   lane_t mem_q [N_LANES];
   logic  valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         valid_q <= 1'b0;
      end else if (load_i) begin
         mem_q   <= d_i;
         valid_q <= 1'b1;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign q_o     = mem_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/sha3_state_serializer.sv
// Captures a 5x5x64 state on sample and streams its first OUT_LANES lanes over valid/ready.
// Define SHA3_SERIALIZER_DOUBLE_BUFFER_EN to add a holding buffer that absorbs one sample mid-stream.
module sha3_state_serializer
   import sha3_pkg::*;
#(
   parameter int OUT_LANES = SHA3_256_DIGEST_LANES,
   parameter int BYTE_SWAP = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  plane_t      isa,
   input  plane_t      isb,
   input  plane_t      isc,
   input  plane_t      isd,
   input  plane_t      ise,
   input  logic        sample,
   output logic        accept,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic [4:0]  out_index,
   output logic        busy,
   output logic        overrun
);

   if (OUT_LANES < 1 || OUT_LANES > SHA3_LANES) begin : g_bad_cfg
      $error("sha3_state_serializer: OUT_LANES must be within 1..25");
   end

   typedef enum logic {IDLE, STREAM} fsm_e;

   localparam logic [4:0] LAST_IDX = 5'(OUT_LANES - 1);

   fsm_e       state_q;
   logic       out_valid_q, out_last_q, busy_q, overrun_q;
   logic [4:0] idx_q, idx_d;

   state_t st;
   lane_t  in_lanes  [OUT_LANES];
   lane_t  act_d     [OUT_LANES];
   lane_t  act_lanes [OUT_LANES];
   lane_t  cur_lanes [32];
   lane_t  sel_lane;
   logic   act_vld, xfer, fin, load_act, clear_act;
   logic   unused_st;

   // Lane i = x + 5*y; planes beyond OUT_LANES are never stored.
   assign st        = {isa, isb, isc, isd, ise};
   assign unused_st = ^st;

   for (genvar g = 0; g < OUT_LANES; g++) begin : g_in
      assign in_lanes[g] = st[g / 5][g % 5];
   end

   // Pad to 32 entries so the 5-bit index selects without range issues.
   for (genvar g = 0; g < 32; g++) begin : g_cur
      if (g < OUT_LANES) begin : g_lane
         assign cur_lanes[g] = act_lanes[g];
      end else begin : g_pad
         assign cur_lanes[g] = '0;
      end
   end

   assign xfer = out_valid_q && out_ready;
   assign fin  = xfer && out_last_q;

`ifdef SHA3_SERIALIZER_DOUBLE_BUFFER_EN
   lane_t hold_lanes [OUT_LANES];
   logic  hold_vld, load_hold, clear_hold;

   // The hold buffer is empty whenever the FSM is idle, so one term covers both states.
   assign accept     = (state_q == IDLE) || !hold_vld;
   assign load_act   = ((state_q == IDLE) && sample) || (fin && (hold_vld || sample));
   assign load_hold  = (state_q == STREAM) && !fin && sample && !hold_vld;
   assign clear_hold = fin && hold_vld;

   always_comb begin
      if (hold_vld) act_d = hold_lanes;
      else          act_d = in_lanes;
   end

   sha3_state_buffer #(.N_LANES(OUT_LANES)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_hold),
      .clear_i (clear_hold),
      .d_i     (in_lanes),
      .q_o     (hold_lanes),
      .valid_o (hold_vld)
   );
`else
   assign accept   = (state_q == IDLE) || fin;
   assign load_act = sample && accept;
   assign act_d    = in_lanes;
`endif

   assign clear_act = fin && !load_act;

   sha3_state_buffer #(.N_LANES(OUT_LANES)) u_act (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_act),
      .clear_i (clear_act),
      .d_i     (act_d),
      .q_o     (act_lanes),
      .valid_o (act_vld)
   );

   assign idx_d = idx_q + 5'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         idx_q       <= '0;
      end else begin
         if (sample && !accept) overrun_q <= 1'b1;
         if (load_act) begin
            state_q     <= STREAM;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            out_last_q  <= (OUT_LANES == 1);
         end else if (xfer) begin
            if (out_last_q) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               idx_q       <= '0;
               out_last_q  <= 1'b0;
            end else begin
               idx_q      <= idx_d;
               out_last_q <= (idx_d == LAST_IDX);
            end
         end
      end
   end

   always_comb begin
      sel_lane = cur_lanes[idx_q];
      if (BYTE_SWAP != 0) sel_lane = lane_byteswap(cur_lanes[idx_q]);
      out_data = (out_valid_q && act_vld) ? sel_lane : '0;
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_index = idx_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_sha3_state_serializer.sv
// Scoreboard bench: driver issues random samples/backpressure, a lane-queue model predicts output lanes.
module tb_sha3_state_serializer;
   import sha3_pkg::*;

   localparam int N = 4;
`ifdef SHA3_SERIALIZER_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   plane_t      isa, isb, isc, isd, ise;
   logic        sample, accept, out_valid, out_ready, out_last, busy, overrun;
   logic [63:0] out_data;
   logic [4:0]  out_index;
   logic        sample2, accept2, out_valid2, ready2, out_last2, busy2, overrun2;
   logic [63:0] out_data2;
   logic [4:0]  out_index2;

   always #5 clk = ~clk;

   sha3_state_serializer #(.OUT_LANES(N), .BYTE_SWAP(0)) u_dut (
      .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
      .sample(sample), .accept(accept), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_index(out_index),
      .busy(busy), .overrun(overrun)
   );

   sha3_state_serializer #(.OUT_LANES(1), .BYTE_SWAP(1)) u_swap (
      .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
      .sample(sample2), .accept(accept2), .out_data(out_data2), .out_valid(out_valid2),
      .out_ready(ready2), .out_last(out_last2), .out_index(out_index2),
      .busy(busy2), .overrun(overrun2)
   );

   typedef struct {
      logic [63:0] dat;
      logic [4:0]  idx;
      logic        last;
   } lane_exp_t;

   typedef struct {
      logic vld;
      logic ovr;
      logic smp;
      logic acc;
      logic in_rst;
      logic post_rst;
   } cyc_exp_t;

   lane_exp_t   lane_q[$];
   cyc_exp_t    cyc_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] cur_st [25];

   // Model: lanes still owed by the active state, and whether a held state is waiting.
   int rem = 0;
   bit held = 1'b0;
   bit ovr_m = 1'b0;
   bit post_rst = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] rev_bytes(input logic [63:0] v);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r = (r << 8) | ((v >> (8 * k)) & 64'hFF);
      return r;
   endfunction

   task automatic drive_state();
      for (int x = 0; x < 5; x++) begin
         isa[x] = cur_st[x];
         isb[x] = cur_st[5 + x];
         isc[x] = cur_st[10 + x];
         isd[x] = cur_st[15 + x];
         ise[x] = cur_st[20 + x];
      end
   endtask

   // One clock of stimulus; pat 0 = random lanes, 1 = 0x0101..*i, 2 = 0xA0+i.
   task automatic cycle(input bit smp, input bit rdy, input bit do_rst, input int pat);
      cyc_exp_t  c;
      lane_exp_t e;
      bit xfer, fin, acc;
      @(posedge clk);
      #1;
      if (smp) begin
         for (int i = 0; i < 25; i++) begin
            if (pat == 1)      cur_st[i] = 64'h0101010101010101 * 64'(i);
            else if (pat == 2) cur_st[i] = 64'(32'hA0 + i);
            else               cur_st[i] = {$urandom, $urandom};
         end
         drive_state();
      end
      sample    = smp && !do_rst;
      out_ready = rdy;
      rst       = do_rst;
      xfer = (rem > 0) && rdy;
      fin  = xfer && (rem == 1);
      acc  = (rem == 0) || (DB ? !held : fin);
      c.vld = (rem > 0);
      c.ovr = ovr_m;
      c.smp = sample;
      c.acc = acc;
      c.in_rst = do_rst;
      c.post_rst = post_rst;
      cyc_q.push_back(c);
      post_rst = do_rst;
      if (do_rst) begin
         rem = 0;
         held = 1'b0;
         ovr_m = 1'b0;
      end else begin
         if (sample && !acc) ovr_m = 1'b1;
         if (sample && acc) begin
            for (int i = 0; i < N; i++) begin
               e.dat = cur_st[i];
               e.idx = 5'(i);
               e.last = (i == N - 1);
               lane_q.push_back(e);
            end
         end
         if (xfer) rem--;
         if (rem == 0 && held) begin
            rem = N;
            held = 1'b0;
         end
         if (sample && acc) begin
            if (rem == 0) rem = N;
            else held = 1'b1;
         end
      end
   endtask

   // Monitor: compares every cycle's outputs against the queued expectations.
   initial begin
      cyc_exp_t  c;
      lane_exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (cyc_q.size() == 0) continue;
         c = cyc_q.pop_front();
         chk("out_valid", 64'(out_valid), 64'(c.vld));
         chk("busy", 64'(busy), 64'(c.vld));
         chk("overrun", 64'(overrun), 64'(c.ovr));
         if (c.smp) chk("accept", 64'(accept), 64'(c.acc));
         if (c.post_rst) begin
            chk("reset_out_data", out_data, 64'd0);
            chk("reset_out_index", 64'(out_index), 64'd0);
            chk("reset_out_last", 64'(out_last), 64'd0);
         end
         if (out_valid === 1'b1) begin
            if (lane_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL lane_scoreboard: unexpected lane index %0d data %h", out_index, out_data);
            end else begin
               e = lane_q[0];
               chk("out_data", out_data, e.dat);
               chk("out_index", 64'(out_index), 64'(e.idx));
               chk("out_last", 64'(out_last), 64'(e.last));
               if (out_ready) void'(lane_q.pop_front());
            end
         end
         if (c.in_rst) lane_q.delete();
      end
   end

   initial begin
      logic [63:0] lane0, prev2;
      bit          have2, smp2;
      int          sp, rp;
      rst = 1'b1;
      sample = 1'b0;
      sample2 = 1'b0;
      ready2 = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 25; i++) cur_st[i] = '0;
      drive_state();
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      // Basic stream with ready held high.
      cycle(1, 1, 0, 1);
      repeat (6) cycle(0, 1, 0, 0);
      // Ready toggling 1,0,0,1,1,0,1.
      cycle(1, 0, 0, 1);
      cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0);
      repeat (3) cycle(0, 1, 0, 0);
      // New sample coincident with the last transfer.
      cycle(1, 1, 0, 1);
      repeat (3) cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 2);
      repeat (6) cycle(0, 1, 0, 0);
      // Sample while stalled at index 1, then reset clears overrun.
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 0, 0, 0);
      repeat (3) cycle(0, 0, 0, 0);
      repeat (12) cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0);
      // Reset at index 2 while stalled, then restart from lane 0.
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(1, 1, 0, 1);
      repeat (6) cycle(0, 1, 0, 0);
      // Randomized phases with varying sample density, backpressure and resets.
      for (int ph = 0; ph < 3; ph++) begin
         sp = (ph == 0) ? 10 : (ph == 1) ? 25 : 60;
         rp = (ph == 0) ? 100 : (ph == 1) ? 50 : 70;
         for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 99) < sp, $urandom_range(0, 99) < rp,
                  (ph != 0) && ($urandom_range(0, 149) == 0), 0);
      end
      repeat (60) cycle(0, 1, 0, 0);
      repeat (3) @(posedge clk);
      #4;
      chk("lanes_drained", 64'(lane_q.size()), 64'd0);
      // Byte-swapped single-lane instance: back-to-back samples, every transfer is last.
      have2 = 1'b0;
      prev2 = '0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         lane0 = (k == 0) ? 64'h0011223344556677 : {$urandom, $urandom};
         smp2 = (k < 6);
         isa[0] = lane0;
         sample2 = smp2;
         #2;
         chk("swap_out_valid", 64'(out_valid2), 64'(have2));
         chk("swap_busy", 64'(busy2), 64'(have2));
         if (have2) begin
            chk("swap_out_data", out_data2, rev_bytes(prev2));
            chk("swap_out_last", 64'(out_last2), 64'd1);
            chk("swap_out_index", 64'(out_index2), 64'd0);
         end
         if (smp2) chk("swap_accept", 64'(accept2), 64'd1);
         have2 = smp2;
         prev2 = lane0;
      end
      sample2 = 1'b0;
      chk("swap_overrun", 64'(overrun2), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
